// File: rtl/mc_alu_sequencer.sv
// Multi-cycle RV32I control sequencer driving the shared ALU datapath.
// Define MC_PERF_CNT_EN to add cycle_cnt/retire_cnt performance counters.
module mc_alu_sequencer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        bcond,
  input  logic        ecall_halt,
  input  logic        mem_ready,
  output logic [3:0]  alu_op,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        pc_write,
  output logic        pc_src,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        is_halted,
  output logic        mem_err,
`ifdef MC_PERF_CNT_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] retire_cnt,
`endif
  output logic [3:0]  state
);

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_LLS = 4'd2;
  localparam logic [3:0] ALU_LRS = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_OR  = 4'd5;
  localparam logic [3:0] ALU_AND = 4'd6;
  localparam logic [3:0] ALU_BEQ = 4'd7;
  localparam logic [3:0] ALU_BNE = 4'd8;
  localparam logic [3:0] ALU_BLT = 4'd9;
  localparam logic [3:0] ALU_BGE = 4'd10;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_EXR   = 4'd2,
    S_EXI   = 4'd3,
    S_ADDR  = 4'd4,
    S_MLD   = 4'd5,
    S_MST   = 4'd6,
    S_WB    = 4'd7,
    S_WBLD  = 4'd8,
    S_BR    = 4'd9,
    S_JAL   = 4'd10,
    S_JALR  = 4'd11,
    S_ECALL = 4'd12,
    S_HALT  = 4'd13,
    S_ERR   = 4'd14
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       mem_wait;

  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  function automatic logic [3:0] arith_op(
    input logic [2:0] f3,
    input logic       sub
  );
    unique case (f3)
      3'b000:  arith_op = sub ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_LLS;
      3'b101:  arith_op = ALU_LRS;
      3'b100:  arith_op = ALU_XOR;
      3'b110:  arith_op = ALU_OR;
      3'b111:  arith_op = ALU_AND;
      default: arith_op = ALU_ADD;
    endcase
  endfunction

  function automatic logic [3:0] branch_op(
    input logic [2:0] f3
  );
    unique case (f3)
      3'b001:  branch_op = ALU_BNE;
      3'b100:  branch_op = ALU_BLT;
      3'b101:  branch_op = ALU_BGE;
      default: branch_op = ALU_BEQ;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IF;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = '0;
    mem_wait = 1'b0;
    case (state_q)
      S_IF: begin
        if (mem_ready) state_d = S_ID;
        else           mem_wait = 1'b1;
      end
      S_ID: begin
        case (opcode)
          OP_R:         state_d = S_EXR;
          OP_I:         state_d = S_EXI;
          OP_LD, OP_ST: state_d = S_ADDR;
          OP_BR:        state_d = S_BR;
          OP_JAL:       state_d = S_JAL;
          OP_JALR:      state_d = S_JALR;
          OP_SYS:       state_d = S_ECALL;
          default:      state_d = S_IF;
        endcase
      end
      S_EXR, S_EXI: state_d = S_WB;
      S_ADDR: state_d = (opcode == OP_LD) ? S_MLD : S_MST;
      S_MLD: begin
        if (mem_ready) state_d = S_WBLD;
        else           mem_wait = 1'b1;
      end
      S_MST: begin
        if (mem_ready) state_d = S_IF;
        else           mem_wait = 1'b1;
      end
      S_WB, S_WBLD, S_BR, S_JAL, S_JALR: state_d = S_IF;
      S_ECALL: state_d = ecall_halt ? S_HALT : S_IF;
      S_HALT, S_ERR: state_d = state_q;
      default: state_d = S_IF;
    endcase
    // a late mem_ready on the last allowed cycle still wins over ERR
    if (mem_wait) begin
      if (wait_q == MaxWait) state_d = S_ERR;
      else                   wait_d  = wait_q + 8'd1;
    end
  end

  always_comb begin
    alu_op    = ALU_ADD;
    alu_src_a = 2'd0;
    alu_src_b = 2'd0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    i_or_d    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 2'd0;
    is_halted = 1'b0;
    mem_err   = 1'b0;
    state     = state_q;
    case (state_q)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_ID: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd2;
      end
      S_EXR: begin
        alu_src_a = 2'd1;
        alu_op    = arith_op(funct3, funct7[5]);
      end
      S_EXI: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        alu_op    = arith_op(funct3, 1'b0);
      end
      S_ADDR: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
      end
      S_MLD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MST: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_WB: reg_write = 1'b1;
      S_WBLD: begin
        reg_write = 1'b1;
        wb_sel    = 2'd1;
      end
      S_BR: begin
        alu_src_a = 2'd1;
        alu_op    = branch_op(funct3);
        pc_write  = bcond;
        pc_src    = 1'b1;
      end
      // PC already holds PC+4, so wb_sel=2 writes the link address
      S_JAL: begin
        pc_write  = 1'b1;
        pc_src    = 1'b1;
        reg_write = 1'b1;
        wb_sel    = 2'd2;
      end
      S_JALR: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        pc_write  = 1'b1;
        reg_write = 1'b1;
        wb_sel    = 2'd2;
      end
      S_HALT: is_halted = 1'b1;
      S_ERR: begin
        is_halted = 1'b1;
        mem_err   = 1'b1;
      end
      default: ;
    endcase
    if (!reset_n) begin
      alu_op    = '0;
      alu_src_a = '0;
      alu_src_b = '0;
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      i_or_d    = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      wb_sel    = '0;
      is_halted = 1'b0;
      mem_err   = 1'b0;
      state     = '0;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_q, retire_q;
  logic        halted, retire;

  assign halted = (state_q == S_HALT) || (state_q == S_ERR);
  assign retire = (state_d == S_IF) &&
                  (state_q inside {S_ID, S_MST, S_WB, S_WBLD,
                                   S_BR, S_JAL, S_JALR, S_ECALL});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_q  <= '0;
      retire_q <= '0;
    end else begin
      if (!halted) cycle_q  <= cycle_q + 32'd1;
      if (retire)  retire_q <= retire_q + 32'd1;
    end
  end

  assign cycle_cnt  = cycle_q;
  assign retire_cnt = retire_q;
`endif

endmodule
